// File: rtl/tapa_fsm_pkg.sv
// State encodings shared by the upper ap_ctrl sequencer and its per-child controllers.
package tapa_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b11,
        DONE  = 2'b10
    } top_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'b00,
        C_START = 2'b01,
        C_RUN   = 2'b11,
        C_DONE  = 2'b10
    } child_state_t;

    // Drain counter width; never narrower than one bit so DRAIN_CYCLES=0 still elaborates.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tapa_child_ctrl.sv
// Drives one child task through the ap_ctrl handshake and reports when it has finished.
module tapa_child_ctrl
    import tapa_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic launch,
    input  logic release_run,
    input  logic detached,
    input  logic ready,
    input  logic done,
    output logic start,
    output logic is_done
);

    child_state_t state_q;
    child_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A detached child returns to idle on ready and is never awaited.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: begin
                if (launch) state_d = C_START;
            end
            C_START: begin
                if (ready) begin
                    if (detached)  state_d = C_IDLE;
                    else if (done) state_d = C_DONE;
                    else           state_d = C_RUN;
                end
            end
            C_RUN: begin
                if (done) state_d = C_DONE;
            end
            C_DONE: begin
                if (release_run) state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

    assign start   = (state_q == C_START);
    assign is_done = (state_q == C_DONE);

endmodule

// File: rtl/tapa_upper_fsm_multi.sv
// Upper-level ap_ctrl sequencer: launches N_CHILD children in parallel, waits on the attached
// ones, optionally drains, then pulses ap_done/ap_ready.
module tapa_upper_fsm_multi
    import tapa_fsm_pkg::*;
#(
    parameter int                 N_CHILD      = 2,
    parameter int                 SCALAR_W     = 64,
    parameter logic [N_CHILD-1:0] DETACH_MASK  = '0,
    parameter int                 DRAIN_CYCLES = 0
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_done,
    output logic                          ap_idle,
    input  logic [SCALAR_W-1:0]           scalar_in,
    output logic [N_CHILD*SCALAR_W-1:0]   child_scalar,
    output logic [N_CHILD-1:0]            child_ap_start,
    input  logic [N_CHILD-1:0]            child_ap_ready,
    input  logic [N_CHILD-1:0]            child_ap_done,
    input  logic [N_CHILD-1:0]            child_ap_idle
);

    localparam int               CNT_W    = cnt_width(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    top_state_t           top_q;
    top_state_t           top_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [SCALAR_W-1:0]  scalar_q;
    logic                 launch;
    logic                 release_run;
    logic                 all_done;
    logic [N_CHILD-1:0]   child_is_done;

    assign launch      = (top_q == IDLE) && ap_start;
    assign release_run = (top_q == DONE);
    assign all_done    = &(child_is_done | DETACH_MASK);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            top_q    <= IDLE;
            cnt_q    <= '0;
            scalar_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (launch) scalar_q <= scalar_in;
        end
    end

    // Drain loads DRAIN_CYCLES-1 and exits on zero, giving exactly DRAIN_CYCLES drain cycles.
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        case (top_q)
            IDLE: begin
                if (ap_start) top_d = BUSY;
            end
            BUSY: begin
                if (all_done) begin
                    if (DRAIN_CYCLES == 0) begin
                        top_d = DONE;
                    end else begin
                        top_d = DRAIN;
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) top_d = DONE;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            DONE: begin
                top_d = IDLE;
            end
            default: top_d = IDLE;
        endcase
    end

    assign ap_done      = (top_q == DONE);
    assign ap_ready     = ap_done;
    assign ap_idle      = (top_q == IDLE);
    assign child_scalar = {N_CHILD{scalar_q}};

    for (genvar g = 0; g < N_CHILD; g++) begin : g_child
        tapa_child_ctrl u_child (
            .clk         (ap_clk),
            .rst_n       (ap_rst_n),
            .launch      (launch),
            .release_run (release_run),
            .detached    (DETACH_MASK[g]),
            .ready       (child_ap_ready[g]),
            .done        (child_ap_done[g]),
            .start       (child_ap_start[g]),
            .is_done     (child_is_done[g])
        );
    end

    // Child idle is observed only; it has no influence on sequencing.
    logic unused_child_idle;
    assign unused_child_idle = ^child_ap_idle;

endmodule

// File: tb/tb_tapa_upper_fsm_multi.sv
// Directed bench for tapa_upper_fsm_multi: three instances (plain, drain=4, child1 detached).
module tb_tapa_upper_fsm_multi;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    logic         start_a, ready_a, done_a, idle_a;
    logic [63:0]  scalar_a;
    logic [127:0] cscal_a;
    logic [1:0]   cstart_a, crdy_a, cdone_a, cidle_a;

    logic         start_b, ready_b, done_b, idle_b;
    logic [63:0]  scalar_b;
    logic [127:0] cscal_b;
    logic [1:0]   cstart_b, crdy_b, cdone_b, cidle_b;

    logic         start_c, ready_c, done_c, idle_c;
    logic [63:0]  scalar_c;
    logic [127:0] cscal_c;
    logic [1:0]   cstart_c, crdy_c, cdone_c, cidle_c;

    tapa_upper_fsm_multi #(.N_CHILD(2), .SCALAR_W(64), .DETACH_MASK(2'b00), .DRAIN_CYCLES(0)) dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start_a), .ap_ready(ready_a),
        .ap_done(done_a), .ap_idle(idle_a), .scalar_in(scalar_a), .child_scalar(cscal_a),
        .child_ap_start(cstart_a), .child_ap_ready(crdy_a), .child_ap_done(cdone_a),
        .child_ap_idle(cidle_a));

    tapa_upper_fsm_multi #(.N_CHILD(2), .SCALAR_W(64), .DETACH_MASK(2'b00), .DRAIN_CYCLES(4)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start_b), .ap_ready(ready_b),
        .ap_done(done_b), .ap_idle(idle_b), .scalar_in(scalar_b), .child_scalar(cscal_b),
        .child_ap_start(cstart_b), .child_ap_ready(crdy_b), .child_ap_done(cdone_b),
        .child_ap_idle(cidle_b));

    tapa_upper_fsm_multi #(.N_CHILD(2), .SCALAR_W(64), .DETACH_MASK(2'b10), .DRAIN_CYCLES(0)) dut_c (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start_c), .ap_ready(ready_c),
        .ap_done(done_c), .ap_idle(idle_c), .scalar_in(scalar_c), .child_scalar(cscal_c),
        .child_ap_start(cstart_c), .child_ap_ready(crdy_c), .child_ap_done(cdone_c),
        .child_ap_idle(cidle_c));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       st;
        logic [1:0] rdy;
        logic [1:0] dn;
        logic       e_done;
        logic       e_idle;
        logic [1:0] e_cs;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic st, input logic [1:0] rdy, input logic [1:0] dn,
                                input logic e_done, input logic e_idle, input logic [1:0] e_cs);
        vec_t v;
        v.st = st; v.rdy = rdy; v.dn = dn;
        v.e_done = e_done; v.e_idle = e_idle; v.e_cs = e_cs;
        return v;
    endfunction

    localparam logic [63:0] BEEF  = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] OTHER = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] PATA  = 64'hA5A5_0000_5A5A_FFFF;

    int          first;
    logic [11:0] dpat, ipat, rpat;

    initial begin
        // minimum-latency run, staggered done, spurious done before ready
        tbl[0]  = mk(1, 2'b00, 2'b00, 0, 1, 2'b00);
        tbl[1]  = mk(0, 2'b11, 2'b11, 0, 0, 2'b11);
        tbl[2]  = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[3]  = mk(0, 2'b00, 2'b00, 1, 0, 2'b00);
        tbl[4]  = mk(1, 2'b00, 2'b00, 0, 1, 2'b00);
        tbl[5]  = mk(0, 2'b11, 2'b00, 0, 0, 2'b11);
        tbl[6]  = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[7]  = mk(0, 2'b00, 2'b01, 0, 0, 2'b00);
        tbl[8]  = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[9]  = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[10] = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[11] = mk(0, 2'b00, 2'b10, 0, 0, 2'b00);
        tbl[12] = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[13] = mk(0, 2'b00, 2'b00, 1, 0, 2'b00);
        tbl[14] = mk(0, 2'b00, 2'b00, 0, 1, 2'b00);
        tbl[15] = mk(1, 2'b00, 2'b00, 0, 1, 2'b00);
        tbl[16] = mk(0, 2'b00, 2'b11, 0, 0, 2'b11);
        tbl[17] = mk(0, 2'b11, 2'b00, 0, 0, 2'b11);
        tbl[18] = mk(0, 2'b00, 2'b11, 0, 0, 2'b00);
        tbl[19] = mk(0, 2'b00, 2'b00, 0, 0, 2'b00);
        tbl[20] = mk(0, 2'b00, 2'b00, 1, 0, 2'b00);
        tbl[21] = mk(0, 2'b00, 2'b00, 0, 1, 2'b00);

        ap_rst_n = 1'b0;
        start_a = 0; scalar_a = '0; crdy_a = '0; cdone_a = '0; cidle_a = 2'b11;
        start_b = 0; scalar_b = '0; crdy_b = '0; cdone_b = '0; cidle_b = 2'b11;
        start_c = 0; scalar_c = '0; crdy_c = '0; cdone_c = '0; cidle_c = 2'b11;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        chk("rst_idle", idle_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_ready", ready_a, 0);
        chk("rst_cstart", cstart_a, 0);
        chk("rst_scalar", cscal_a, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge ap_clk);
            chk($sformatf("tbl%0d_done", i), done_a, tbl[i].e_done);
            chk($sformatf("tbl%0d_ready", i), ready_a, tbl[i].e_done);
            chk($sformatf("tbl%0d_idle", i), idle_a, tbl[i].e_idle);
            chk($sformatf("tbl%0d_cstart", i), cstart_a, tbl[i].e_cs);
            start_a = tbl[i].st;
            crdy_a  = tbl[i].rdy;
            cdone_a = tbl[i].dn;
        end
        @(negedge ap_clk);
        start_a = 0; crdy_a = '0; cdone_a = '0;

        // drain of 4 cycles, scalar held across a mid-run change
        scalar_b = BEEF; start_b = 1;
        @(negedge ap_clk);
        start_b = 0; scalar_b = OTHER; crdy_b = 2'b11; cdone_b = 2'b11;
        chk("drain_scalar0", cscal_b[63:0], BEEF);
        chk("drain_scalar1", cscal_b[127:64], BEEF);
        first = -1;
        for (int k = 2; k < 14; k++) begin
            @(negedge ap_clk);
            if (k == 2) begin crdy_b = '0; cdone_b = '0; end
            if (k == 5) chk("drain_busy_idle", idle_b, 0);
            if (done_b && first < 0) first = k;
        end
        chk("drain_latency", first, 7);
        chk("drain_scalar_hold", cscal_b, {OTHER ^ OTHER ^ BEEF, BEEF});

        // child1 detached and never ready
        @(negedge ap_clk); start_c = 1;
        @(negedge ap_clk); start_c = 0; crdy_c = 2'b01; cdone_c = 2'b01;
        chk("det_cs_r1", cstart_c, 2'b11);
        @(negedge ap_clk); crdy_c = '0; cdone_c = '0;
        chk("det_cs_r2", cstart_c, 2'b10);
        @(negedge ap_clk);
        chk("det_done_r3", done_c, 1);
        chk("det_cs_r3", cstart_c, 2'b10);
        @(negedge ap_clk);
        chk("det_idle_r4", idle_c, 1);
        chk("det_cs_r4", cstart_c, 2'b10);
        start_c = 1;
        @(negedge ap_clk); start_c = 0; crdy_c = 2'b01; cdone_c = 2'b01;
        chk("det_cs_r5", cstart_c, 2'b11);
        @(negedge ap_clk); crdy_c = '0; cdone_c = '0;
        chk("det_cs_r6", cstart_c, 2'b10);
        @(negedge ap_clk);
        chk("det_done_r7", done_c, 1);
        @(negedge ap_clk); crdy_c = 2'b10;
        @(negedge ap_clk); crdy_c = '0;
        chk("det_cs_released", cstart_c, 2'b00);

        // ap_start held high: back-to-back runs with one idle cycle between
        dpat = '0; ipat = '0; rpat = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge ap_clk);
            dpat[k] = done_a;
            ipat[k] = idle_a;
            rpat[k] = ready_a;
            if (k == 0) begin start_a = 1; crdy_a = 2'b11; cdone_a = 2'b11; end
        end
        @(negedge ap_clk);
        start_a = 0; crdy_a = '0; cdone_a = '0;
        chk("b2b_done_pattern", dpat, 12'h888);
        chk("b2b_ready_pattern", rpat, 12'h888);
        chk("b2b_idle_pattern", ipat, 12'h111);

        // asynchronous reset mid-run (dut_a in BUSY, dut_b in DRAIN)
        @(negedge ap_clk);
        start_a = 1; scalar_a = PATA; start_b = 1; crdy_b = 2'b11; cdone_b = 2'b11;
        @(negedge ap_clk);
        start_a = 0; start_b = 0;
        @(negedge ap_clk);
        crdy_b = '0; cdone_b = '0;
        @(negedge ap_clk);
        chk("pre_rst_cs_a", cstart_a, 2'b11);
        chk("pre_rst_scalar_a", cscal_a[63:0], PATA);
        chk("pre_rst_idle_b", idle_b, 0);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("async_idle_a", idle_a, 1);
        chk("async_cs_a", cstart_a, 2'b00);
        chk("async_scalar_a", cscal_a, 0);
        chk("async_idle_b", idle_b, 1);
        chk("async_done_b", done_b, 0);
        chk("async_scalar_b", cscal_b, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk); start_a = 1;
        @(negedge ap_clk); start_a = 0; crdy_a = 2'b11; cdone_a = 2'b11;
        first = -1;
        for (int k = 2; k < 10; k++) begin
            @(negedge ap_clk);
            if (k == 2) begin crdy_a = '0; cdone_a = '0; end
            if (done_a && first < 0) first = k;
        end
        chk("post_rst_latency", first, 3);
        chk("post_rst_idle", idle_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
